// File: rtl/vga_pixel_fifo_if.sv
// Pixel stream from the frame-buffer reader into the VGA prefetch buffer.
// Valid/ready: a word transfers on a rising clock edge where in_valid and in_ready are both 1.
interface vga_pixel_fifo_if #(
    parameter int DW = 12
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_sof;
    logic          in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_sof,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sof,
        output in_ready
    );
endinterface

// File: rtl/vga_pixel_fifo.sv
// Prefetch FIFO between the frame-buffer reader and the VGA timing generator.
// It realigns on frame_start by discarding input until a start-of-frame word arrives.
module vga_pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 12,
    parameter int CW    = 16
) (
    input  logic                     MAX10_CLK1_50,
    input  logic                     RESET_N,
    vga_pixel_fifo_if.slave          up,
    input  logic                     pix_req,
    input  logic                     frame_start,
    output logic [3:0]               VGA_R,
    output logic [3:0]               VGA_G,
    output logic [3:0]               VGA_B,
    output logic                     underrun,
    output logic [CW-1:0]            underrun_count,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic {
        ST_SEEK = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [DW-1:0]   rgb_q, rgb_d;
    logic            underrun_q, underrun_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   mem_q [DEPTH];

    logic            ready;
    logic            push;
    logic            pop;

    // Ready comes from registered state only, so a full buffer never sees a write attempt.
    assign ready = RESET_N && ((state_q == ST_SEEK) || (level_q != FULL_LEVEL));

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rgb_d      = '0;
        underrun_d = underrun_q;
        count_d    = count_q;
        push       = 1'b0;
        pop        = 1'b0;

        if (frame_start) begin
            // Frame restart wins over everything else in the same cycle.
            state_d  = ST_SEEK;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (up.in_valid && ready) begin
                case (state_q)
                    ST_SEEK: begin
                        if (up.in_sof) begin
                            push    = 1'b1;
                            state_d = ST_RUN;
                        end
                    end
                    ST_RUN:  push = 1'b1;
                    default: push = 1'b0;
                endcase
            end

            if (pix_req) begin
                if (level_q != '0) begin
                    pop      = 1'b1;
                    rgb_d    = mem_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end else begin
                    underrun_d = 1'b1;
                    if (~&count_q) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end

            if (push && !pop) begin
                level_d = level_q + 1'b1;
            end else if (!push && pop) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (!RESET_N) begin
            state_q    <= ST_SEEK;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rgb_q      <= '0;
            underrun_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rgb_q      <= rgb_d;
            underrun_q <= underrun_d;
            count_q    <= count_d;
        end
    end

    // Storage has no reset; only entries below level are ever read.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (RESET_N && push) begin
            mem_q[wr_ptr_q] <= up.in_data;
        end
    end

    assign up.in_ready     = ready;
    assign VGA_R           = rgb_q[11:8];
    assign VGA_G           = rgb_q[7:4];
    assign VGA_B           = rgb_q[3:0];
    assign underrun        = underrun_q;
    assign underrun_count  = count_q;
    assign level           = level_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Bench for vga_pixel_fifo: directed scenarios plus random traffic against a queue-based model.
// CW is narrowed so that counter saturation is reachable in a short run.
module tb_vga_pixel_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 12;
    localparam int CW    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_req = 1'b0;
    logic frame_start = 1'b0;
    logic [3:0] vga_r, vga_g, vga_b;
    logic underrun;
    logic [CW-1:0] ucnt;
    logic [LW-1:0] level;
    logic dbg_state;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    vga_pixel_fifo_if #(.DW(DW)) up_if ();

    vga_pixel_fifo #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
        .MAX10_CLK1_50  (clk),
        .RESET_N        (rst_n),
        .up             (up_if.slave),
        .pix_req        (pix_req),
        .frame_start    (frame_start),
        .VGA_R          (vga_r),
        .VGA_G          (vga_g),
        .VGA_B          (vga_b),
        .underrun       (underrun),
        .underrun_count (ucnt),
        .level          (level),
        .dbg_state      (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a queue of pixels, alignment is a single flag.
    logic [DW-1:0] ref_q[$];
    logic [DW-1:0] exp_q[$];
    bit m_seek = 1'b1;
    bit m_und = 1'b0;
    int m_cnt = 0;

    always @(posedge clk) begin : model_p
        logic [DW-1:0] e;
        bit rdy;
        e = '0;
        rdy = rst_n && (m_seek || ref_q.size() != DEPTH);
        if (!rst_n) begin
            ref_q.delete();
            m_seek = 1'b1;
            m_und  = 1'b0;
            m_cnt  = 0;
        end else if (frame_start) begin
            ref_q.delete();
            m_seek = 1'b1;
        end else begin
            if (pix_req) begin
                if (ref_q.size() > 0) begin
                    e = ref_q.pop_front();
                end else begin
                    m_und = 1'b1;
                    if (m_cnt < CMAX) m_cnt++;
                end
            end
            if (up_if.in_valid && rdy) begin
                if (!m_seek) begin
                    ref_q.push_back(up_if.in_data);
                end else if (up_if.in_sof) begin
                    ref_q.push_back(up_if.in_data);
                    m_seek = 1'b0;
                end
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: every cycle the registered outputs are compared against the model.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check("rgb", {vga_r, vga_g, vga_b}, exp_q.pop_front());
        end
        check("level", level, ref_q.size());
        check("in_ready", up_if.in_ready, rst_n && (m_seek || ref_q.size() != DEPTH));
        check("underrun", underrun, m_und);
        check("underrun_count", ucnt, m_cnt);
        check("state", dbg_state, !m_seek);
    end

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit sof,
                         input bit req, input bit fs);
        up_if.in_valid = v;
        up_if.in_data  = d;
        up_if.in_sof   = sof;
        pix_req        = req;
        frame_start    = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        up_if.in_valid = 1'b0;
        up_if.in_data  = '0;
        up_if.in_sof   = 1'b0;

        // Reset held with traffic offered
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 12'h777, 1'b1, 1'b1, 1'b0);
        check("rst_in_ready", up_if.in_ready, 0);
        check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        check("rst_level", level, 0);
        check("rst_count", ucnt, 0);
        rst_n = 1'b1;
        up_if.in_valid = 1'b0;
        pix_req = 1'b0;
        #1;
        check("seek_ready", up_if.in_ready, 1);

        // SEEK alignment
        drive(1'b1, 12'h123, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 12'h456, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 12'hF00, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 12'h0F0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 12'h00F, 1'b0, 1'b0, 1'b0);
        check("align_level", level, 3);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("align_r", {vga_r, vga_g, vga_b}, 12'hF00);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("align_g", {vga_r, vga_g, vga_b}, 12'h0F0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("align_b", {vga_r, vga_g, vga_b}, 12'h00F);
        check("align_empty", level, 0);

        // Full and backpressure
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 12'hA00, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 20; i++) drive(1'b1, 12'hA00 + 12'(i), 1'b0, 1'b0, 1'b0);
        check("full_level", level, 16);
        check("full_ready", up_if.in_ready, 0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("full_pop_rgb", {vga_r, vga_g, vga_b}, 12'hA00);
        check("full_pop_level", level, 15);
        check("full_ready_back", up_if.in_ready, 1);
        drive(1'b1, 12'hA55, 1'b0, 1'b0, 1'b0);
        check("full_refill", level, 16);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
            check("full_order", {vga_r, vga_g, vga_b}, (i < 15) ? 12'hA01 + 12'(i) : 12'hA55);
        end

        // Underrun in RUN with an empty buffer
        for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("und_flag", underrun, 1);
        check("und_count", ucnt, 5);
        check("und_rgb", {vga_r, vga_g, vga_b}, 0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("und_flag_fs", underrun, 1);
        check("und_count_fs", ucnt, 5);

        // Frame restart mid-line
        drive(1'b1, 12'hB00, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) drive(1'b1, 12'hB00 + 12'(i), 1'b0, 1'b0, 1'b0);
        check("restart_pre", level, 10);
        drive(1'b1, 12'hBAD, 1'b0, 1'b1, 1'b1);
        check("restart_level", level, 0);
        check("restart_state", dbg_state, 0);
        check("restart_count", ucnt, 5);
        drive(1'b1, 12'hC00, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 12'hC01, 1'b0, 1'b1, 1'b0);
        check("restart_first", {vga_r, vga_g, vga_b}, 12'hC00);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("restart_second", {vga_r, vga_g, vga_b}, 12'hC01);

        // Counter saturation
        for (int i = 0; i < 20; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("sat_count", ucnt, CMAX);

        // Streaming from a fresh reset
        rst_n = 1'b0;
        idle();
        idle();
        rst_n = 1'b1;
        drive(1'b1, 12'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) drive(1'b1, 12'(i), 1'b0, 1'b0, 1'b0);
        check("stream_prefill", level, 8);
        for (int i = 8; i < 808; i++) drive(1'b1, 12'(i), 1'b0, 1'b1, 1'b0);
        check("stream_level", level, 8);
        check("stream_last", {vga_r, vga_g, vga_b}, 12'd799);
        check("stream_underrun", underrun, 0);

        // Random traffic in phases of varying push/pop pressure
        for (int p = 0; p < 12; p++) begin
            int vrate = $urandom_range(1, 4);
            int rrate = $urandom_range(0, 4);
            for (int i = 0; i < 250; i++) begin
                drive($urandom_range(0, 4) < vrate, 12'($urandom), $urandom_range(0, 15) == 0,
                      $urandom_range(0, 4) < rrate, $urandom_range(0, 99) == 0);
            end
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_pixel_fifo.md
# vga_pixel_fifo

Pixel prefetch buffer directly upstream of the 800x600 VGA timing generator. Accepts RGB444 pixels from the frame-buffer reader over a valid/ready stream and hands one pixel per `pix_req` strobe to the timing generator, which drives `VGA_R/G/B`. Realigns to each new frame on `frame_start`. Reports underrun when the timing generator requests a pixel the buffer does not hold.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 4..256
- `DW`, 12: pixel width; {R[11:8], G[7:4], B[3:0]}
- `CW`, 16: underrun counter width
- `MAX10_CLK1_50`  in  1  sole clock, 50 MHz; all logic on posedge
- `RESET_N`  in  1  synchronous, active-low reset
- `in_valid`  in  1  upstream pixel valid
- `in_data`  in  DW  upstream pixel
- `in_sof`  in  1  qualifies `in_data` as first pixel (top-left) of a frame
- `in_ready`  out  1  buffer accepts `in_data` this cycle
- `pix_req`  in  1  timing generator consumes one pixel this cycle (active video only)
- `frame_start`  in  1  one-cycle pulse from timing generator during vertical blanking before each frame
- `VGA_R`, `VGA_G`, `VGA_B`  out  4 each  registered pixel colour
- `underrun`  out  1  sticky: a `pix_req` found the buffer empty
- `underrun_count`  out  CW  saturating count of empty `pix_req` cycles
- `level`  out  clog2(DEPTH)+1  registered occupancy, 0..DEPTH

## Operation
- Storage: DEPTH x DW circular buffer; write and read pointers clog2(DEPTH) bits, wrap modulo DEPTH; `level` tracks occupancy.
- State machine, 2 states:
  - SEEK (reset state): `in_ready`=1. Words with `in_sof`=0 accepted and discarded. A word with `in_sof`=1 is written; next state RUN.
  - RUN: `in_ready` = (`level` != DEPTH). Push when `in_valid && in_ready`. An `in_sof`=1 word is stored as a normal pixel; no realignment.
  - `frame_start`=1 in any state: next state SEEK; pointers and `level` cleared; any push/pop in that cycle is dropped.
- Pop: `pix_req`=1, `frame_start`=0, `level`>0: head pixel registered onto `VGA_R/G/B`; read pointer advances.
- Underrun: `pix_req`=1, `frame_start`=0, `level`=0, in either state: RGB registered as 0; `underrun` set; `underrun_count` +1, saturating at 2^CW-1. A push in the same cycle is stored normally; there is no bypass.
- `pix_req`=0: RGB registered as 0 (blanking black).
- Simultaneous push and pop with `level` in 1..DEPTH-1: `level` unchanged.
- Full: `in_ready` derives from registered `level`, so no write is attempted at `level`=DEPTH; a pop at full raises `in_ready` on the next cycle.
- `underrun` and `underrun_count` are cleared only by reset. `frame_start` does not clear them.

## Timing
- Reset (`RESET_N`=0 at a posedge): state SEEK, pointers 0, `level` 0, RGB 0, `underrun` 0, `underrun_count` 0. `in_ready` forced 0 while `RESET_N`=0. No push/pop occurs during reset.
- Read latency: `pix_req` at edge N produces RGB on the outputs after edge N, valid for cycle N+1; exactly 1 cycle.
- Write-to-read latency: a word pushed at edge N is poppable at edge N+1.
- `level`, `underrun` and `underrun_count` update at the same edge as the push/pop that causes them.
- `frame_start` takes priority over push, pop and underrun in the same cycle.
- Sustained throughput: one push and one pop per cycle.

## Test plan
- Reset: hold `RESET_N`=0 for 3 cycles with `in_valid`=1 and `pix_req`=1 -> `in_ready`=0, RGB=0, `level`=0, `underrun_count`=0; release -> `in_ready`=1 (SEEK).
- SEEK alignment: push 0x123, 0x456 with `in_sof`=0, then 0xF00 with `in_sof`=1, 0x0F0, 0x00F -> `level`=3. Three `pix_req` cycles -> RGB (F,0,0), (0,F,0), (0,0,F) on consecutive cycles, then `level`=0.
- Full/backpressure (DEPTH=16): after SOF, offer 20 words with no reads -> `in_ready` drops after the 16th, `level`=16. One `pix_req` -> `level`=15, `in_ready`=1 next cycle, word 17 accepted in FIFO order.
- Underrun: RUN with `level`=0, `pix_req` for 5 cycles -> RGB=0, `underrun`=1, `underrun_count`=5. Then `frame_start` -> `underrun` still 1, count still 5.
- Frame restart mid-line: `level`=10, pulse `frame_start` in the same cycle as `in_valid`=1 and `pix_req`=1 -> next cycle `level`=0, state SEEK, count unchanged, pushed word absent from subsequent output.
- Streaming: `level`=8, simultaneous push/pop for 800 cycles of an incrementing pattern -> `level` stays 8, output sequence equals input delayed by 8 pops, `underrun`=0.
